sram_resp: RTL and testbench
============================

Name: sram_resp

Overview:
- Clocked behavioural responder for the CPU's 8-bit asynchronous-style SRAM bus: the target end of the cen/wen/oen/dq strobes the CPU controller generates.
- Serves instruction fetches and LDM reads combinationally from an internal array.
- Commits STM writes at the end of each write pulse.
- Provides a preload port for program images, access counters and sticky protocol-error flags for bench use.

Parameters:
- AW, 8, address width; array depth is 2**AW bytes.
- CW, 16, width of the rd_cnt and wr_cnt access counters.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- cen  input  1  chip enable, active-low.
- wen  input  1  write enable, active-low.
- oen  input  1  output enable, active-low.
- addr  input  AW  byte address from the CPU address mux.
- dq_in  input  8  write data, valid while the CPU has den=1.
- dq_out  output  8  read data.
- dq_oe  output  1  responder drives the dq bus.
- ld_en  input  1  preload strobe.
- ld_addr  input  AW  preload address.
- ld_data  input  8  preload data.
- rd_cnt  output  CW  read accesses, saturating.
- wr_cnt  output  CW  committed writes, saturating.
- err_cont  output  1  sticky: cen, wen and oen sampled low together.
- err_addr  output  1  sticky: addr changed during a write pulse.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset:
  - State goes to IDLE; rd_cnt=0, wr_cnt=0, err_cont=0, err_addr=0; wa and wd cleared.
  - Array contents are NOT reset; preloaded data survives rst.
  - A pending (uncommitted) write is discarded.
- Read path (combinational, zero latency):
  - rd_act = ~cen & ~oen & wen.
  - dq_oe = rd_act; dq_out = mem[addr] when rd_act, else 8'h00.
  - Data must be valid in the same cycle the strobes are low, because the CPU latches at the end of that cycle.
- Read count: rd_act is registered as rd_act_q. rd_cnt increments on each edge where rd_act=1 and rd_act_q=0, so a multi-cycle read counts once. It saturates at all-ones.
- Write FSM, states IDLE and WRITE; wr_low = ~cen & ~wen:
  - IDLE: if wr_low, then wa<=addr, wd<=dq_in, go to WRITE. Otherwise stay in IDLE.
  - WRITE while wr_low: wd<=dq_in, so the last low cycle's data wins. If addr != wa, set err_addr; wa is not updated.
  - WRITE when wr_low is 0 (pulse ended by wen or cen rising): mem[wa]<=wd, wr_cnt++ (saturating), go to IDLE.
  - Commit edge = first edge sampling wen or cen high. The new value is readable in the cycle after the commit edge.
  - Minimum write cycle is 2 clocks (1 low cycle + 1 commit cycle). Back-to-back writes separated by one high cycle both commit.
- Contention: on any edge sampling cen=0, wen=0, oen=0, set err_cont. dq_oe stays 0 because wen is low. The write proceeds normally.
- Preload:
  - ld_en=1 at an edge writes mem[ld_addr]<=ld_data. This is independent of the bus strobes and is not counted.
  - Same edge as a commit to the same address: preload wins.
  - Same edge as a commit to a different address: both are written.
- Reads of an address with a write pending in WRITE return the old array value; there is no forwarding.
- Unused states recover to IDLE.

Test Plan:
1. Preload mem[8'h10]=8'hA5, then hold cen=0, oen=0, wen=1, addr=8'h10 for 1 cycle -> same-cycle dq_out=8'hA5, dq_oe=1; rd_cnt=1 after the edge. Holding for 3 more cycles leaves rd_cnt at 1.
2. CPU STM sequence: addr=8'h20, cen=0, wen=0, dq_in=8'h3C for 1 cycle, then cen=1, wen=1 -> commit on the next edge; a read of 8'h20 returns 8'h3C; wr_cnt=1; err flags remain 0.
3. Write pulse of 3 low cycles with dq_in = 11, 22, 33 at addr=8'h05 -> mem[8'h05]=8'h33, wr_cnt increments by exactly 1. Repeat with addr changed to 8'h06 in cycle 2 -> err_addr=1 and data lands at 8'h05.
4. cen=0, wen=0, oen=0 for one cycle at addr=8'h07, dq_in=8'h99 -> err_cont=1 and stays 1; dq_oe=0 throughout; mem[8'h07]=8'h99 after commit; rst for one cycle clears err_cont.
5. Assert rst while in WRITE (addr=8'h40, dq_in=8'hEE, old value 8'h11) -> no commit, mem[8'h40] still reads 8'h11, wr_cnt=0, state IDLE. Preloaded data at other addresses is intact.
6. Commit to 8'h50 (data 8'h01) on the same edge as ld_en with ld_addr=8'h50, ld_data=8'h02 -> reads 8'h02, wr_cnt increments. Separately, with CW=4, 17 writes -> wr_cnt saturates at 4'hF.

Source files
------------

// File: rtl/sram_resp.sv
// Behavioural target for the CPU's 8-bit SRAM bus: combinational reads, writes
// committed when the write pulse ends, plus preload, access counters and error flags.
module sram_resp #(
  parameter int AW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          wen,
  input  logic          oen,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    dq_in,
  output logic [7:0]    dq_out,
  output logic          dq_oe,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_data,
  output logic [CW-1:0] rd_cnt,
  output logic [CW-1:0] wr_cnt,
  output logic          err_cont,
  output logic          err_addr
);

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [0:(1<<AW)-1];
  logic          rd_act, rd_act_q, wr_low;
  logic          capture, commit;
  logic [AW-1:0] wa;
  logic [7:0]    wd;

  assign rd_act = ~cen & ~oen & wen;
  assign wr_low = ~cen & ~wen;
  assign dq_oe  = rd_act;
  // The CPU latches at the end of the strobe cycle, so no read register here.
  assign dq_out = rd_act ? mem[addr] : 8'h00;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE:    if (wr_low) begin
                 capture   = 1'b1;
                 state_nxt = WRITE;
               end
      WRITE:   if (!wr_low) begin
                 commit    = 1'b1;
                 state_nxt = IDLE;
               end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rd_act_q <= 1'b0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      err_cont <= 1'b0;
      err_addr <= 1'b0;
      wa       <= '0;
      wd       <= '0;
    end else begin
      state    <= state_nxt;
      rd_act_q <= rd_act;
      if (rd_act && !rd_act_q && rd_cnt != '1) rd_cnt <= rd_cnt + CW'(1);
      if (commit && wr_cnt != '1)              wr_cnt <= wr_cnt + CW'(1);
      if (wr_low && !oen)                      err_cont <= 1'b1;
      if (capture)                             wa <= addr;
      // Data follows the bus every low cycle; the address is frozen at capture.
      if (wr_low)                              wd <= dq_in;
      if (state == WRITE && wr_low && addr != wa) err_addr <= 1'b1;
    end
  end

  // Array is never reset; preload is written last so it wins a same-address commit.
  always_ff @(posedge clk) begin
    if (commit && !rst) mem[wa] <= wd;
    if (ld_en)          mem[ld_addr] <= ld_data;
  end

endmodule

// File: tb/tb_sram_resp.sv
// Randomised + directed bench for sram_resp; reads are scoreboarded against an
// array model, counters and flags are checked after every clock edge.
module tb_sram_resp;
  logic       clk = 1'b0;
  logic       rst, cen, wen, oen, ld_en;
  logic [7:0] addr, dq_in, ld_addr, ld_data;
  logic [7:0] dq_out, dq_out4;
  logic       dq_oe, dq_oe4;
  logic [15:0] rd_cnt, wr_cnt;
  logic [3:0]  rd_cnt4, wr_cnt4;
  logic       err_cont, err_addr, err_cont4, err_addr4;

  sram_resp #(.AW(8), .CW(16)) dut (
    .clk(clk), .rst(rst), .cen(cen), .wen(wen), .oen(oen), .addr(addr),
    .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe), .ld_en(ld_en),
    .ld_addr(ld_addr), .ld_data(ld_data), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt),
    .err_cont(err_cont), .err_addr(err_addr));

  sram_resp #(.AW(8), .CW(4)) dut4 (
    .clk(clk), .rst(rst), .cen(cen), .wen(wen), .oen(oen), .addr(addr),
    .dq_in(dq_in), .dq_out(dq_out4), .dq_oe(dq_oe4), .ld_en(ld_en),
    .ld_addr(ld_addr), .ld_data(ld_data), .rd_cnt(rd_cnt4), .wr_cnt(wr_cnt4),
    .err_cont(err_cont4), .err_addr(err_addr4));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  // Reference model: byte array, one pending write, plain integer counters.
  logic [7:0] mem_m [256];
  bit         pend, rdq, m_ec, m_ea;
  logic [7:0] pa, pd;
  int         rc, wc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  // Monitor: every driven read must match the oldest queued expectation.
  always @(negedge clk) begin
    if (dq_oe === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: dq_oe=1 at addr %0h with nothing expected", addr);
      end else begin
        chk("rd_data", {24'h0, dq_out}, {24'h0, exp_q.pop_front()});
      end
    end else begin
      chk("idle_dq", {24'h0, dq_out}, 32'h0);
    end
  end

  task automatic step();
    bit rd, wl;
    rd = !cen && !oen && wen;
    wl = !cen && !wen;
    if (rd) exp_q.push_back(mem_m[addr]);
    @(posedge clk);
    if (rst) begin
      pend = 0; rdq = 0; rc = 0; wc = 0; m_ec = 0; m_ea = 0;
    end else begin
      if (wl && !oen) m_ec = 1;
      if (rd && !rdq) rc++;
      rdq = rd;
      if (pend && !wl) begin
        mem_m[pa] = pd;
        wc++;
        pend = 0;
      end else if (wl) begin
        if (!pend) begin
          pend = 1;
          pa   = addr;
        end else if (addr != pa) m_ea = 1;
        pd = dq_in;
      end
    end
    if (ld_en) mem_m[ld_addr] = ld_data;
    #1;
    chk("rd_cnt",    {16'h0, rd_cnt},  sat(rc, 65535));
    chk("wr_cnt",    {16'h0, wr_cnt},  sat(wc, 65535));
    chk("rd_cnt4",   {28'h0, rd_cnt4}, sat(rc, 15));
    chk("wr_cnt4",   {28'h0, wr_cnt4}, sat(wc, 15));
    chk("err_cont",  {31'h0, err_cont},  {31'h0, m_ec});
    chk("err_addr",  {31'h0, err_addr},  {31'h0, m_ea});
    chk("err_cont4", {31'h0, err_cont4}, {31'h0, m_ec});
    chk("err_addr4", {31'h0, err_addr4}, {31'h0, m_ea});
  endtask

  task automatic bus(input bit c, input bit w, input bit o, input logic [7:0] a, input logic [7:0] d);
    cen = c; wen = w; oen = o; addr = a; dq_in = d;
    ld_en = 0; rst = 0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    bus(1, 1, 1, addr, 8'h00);
    ld_en = 1; ld_addr = a; ld_data = d;
    step();
    ld_en = 0;
  endtask

  // Same-cycle read value checked against a fixed expectation.
  task automatic peek(input string name, input logic [7:0] exp);
    #2;
    chk(name, {23'h0, dq_oe, dq_out}, {23'h0, 1'b1, exp});
    chk({name, "_cw4"}, {23'h0, dq_oe4, dq_out4}, {23'h0, 1'b1, exp});
  endtask

  initial begin
    rst = 1; cen = 1; wen = 1; oen = 1; addr = 0; dq_in = 0;
    ld_en = 0; ld_addr = 0; ld_data = 0;
    @(posedge clk); #1;
    step(); step();
    rst = 0;
    for (int i = 0; i < 256; i++) preload(8'(i), 8'($urandom));

    // Multi-cycle read counts once
    preload(8'h10, 8'hA5);
    bus(0, 1, 0, 8'h10, 8'h00); peek("t1_read", 8'hA5); step();
    chk("t1_rd_cnt", {16'h0, rd_cnt}, 32'd1);
    for (int i = 0; i < 3; i++) step();
    chk("t1_rd_hold", {16'h0, rd_cnt}, 32'd1);
    bus(1, 1, 1, 8'h00, 8'h00); step();

    // Minimum STM write
    bus(0, 0, 1, 8'h20, 8'h3C); step();
    bus(1, 1, 1, 8'h20, 8'h00); step();
    bus(0, 1, 0, 8'h20, 8'h00); peek("t2_read", 8'h3C); step();
    chk("t2_wr_cnt", {16'h0, wr_cnt}, 32'd1);
    chk("t2_errs", {30'h0, err_cont, err_addr}, 32'd0);
    bus(1, 1, 1, 8'h00, 8'h00); step();

    // Long pulse: last data wins; address change flagged, data lands at first address
    bus(0, 0, 1, 8'h05, 8'h11); step();
    bus(0, 0, 1, 8'h05, 8'h22); step();
    bus(0, 0, 1, 8'h05, 8'h33); step();
    bus(1, 1, 1, 8'h05, 8'h00); step();
    chk("t3_wr_cnt", {16'h0, wr_cnt}, 32'd2);
    bus(0, 1, 0, 8'h05, 8'h00); peek("t3_read", 8'h33); step();
    bus(1, 1, 1, 8'h05, 8'h00); step();
    bus(0, 0, 1, 8'h05, 8'h44); step();
    bus(0, 0, 1, 8'h06, 8'h55); step();
    bus(1, 1, 1, 8'h06, 8'h00); step();
    chk("t3_err_addr", {31'h0, err_addr}, 32'd1);
    bus(0, 1, 0, 8'h05, 8'h00); peek("t3_read_a", 8'h55); step();
    bus(1, 1, 1, 8'h05, 8'h00); step();

    // Contention: flag sticks, write still commits, reset clears it
    bus(0, 0, 0, 8'h07, 8'h99); step();
    chk("t4_err_cont", {31'h0, err_cont}, 32'd1);
    bus(1, 1, 1, 8'h07, 8'h00); step();
    bus(0, 1, 0, 8'h07, 8'h00); peek("t4_read", 8'h99); step();
    chk("t4_err_hold", {31'h0, err_cont}, 32'd1);
    bus(1, 1, 1, 8'h00, 8'h00); rst = 1; step(); rst = 0;
    chk("t4_err_clr", {31'h0, err_cont}, 32'd0);

    // Reset during a pending write discards it
    preload(8'h40, 8'h11);
    bus(0, 0, 1, 8'h40, 8'hEE); step();
    bus(1, 1, 1, 8'h40, 8'h00); rst = 1; step(); rst = 0;
    chk("t5_wr_cnt", {16'h0, wr_cnt}, 32'd0);
    bus(0, 1, 0, 8'h40, 8'h00); peek("t5_read", 8'h11); step();
    bus(0, 1, 0, 8'h10, 8'h00); peek("t5_keep", 8'hA5); step();
    bus(1, 1, 1, 8'h00, 8'h00); step();

    // Commit vs preload on the same edge
    bus(0, 0, 1, 8'h50, 8'h01); step();
    bus(1, 1, 1, 8'h50, 8'h00); ld_en = 1; ld_addr = 8'h50; ld_data = 8'h02; step(); ld_en = 0;
    chk("t6_wr_cnt", {16'h0, wr_cnt}, 32'd1);
    bus(0, 1, 0, 8'h50, 8'h00); peek("t6_ld_wins", 8'h02); step();
    bus(1, 1, 1, 8'h00, 8'h00); step();
    bus(0, 0, 1, 8'h51, 8'h77); step();
    bus(1, 1, 1, 8'h51, 8'h00); ld_en = 1; ld_addr = 8'h52; ld_data = 8'h88; step(); ld_en = 0;
    bus(0, 1, 0, 8'h51, 8'h00); peek("t6_both_a", 8'h77); step();
    bus(1, 1, 1, 8'h00, 8'h00); step();
    bus(0, 1, 0, 8'h52, 8'h00); peek("t6_both_b", 8'h88); step();
    bus(1, 1, 1, 8'h00, 8'h00); step();

    // Saturation of the narrow counter
    for (int i = 0; i < 17; i++) begin
      bus(0, 0, 1, 8'(8'h60 + i), 8'(i)); step();
      bus(1, 1, 1, 8'h00, 8'h00); step();
    end
    chk("t6_wr_sat4", {28'h0, wr_cnt4}, 32'hF);
    chk("t6_wr_cnt16", {16'h0, wr_cnt}, 32'd19);

    // Random bus traffic over a small address window
    for (int i = 0; i < 4000; i++) begin
      cen = ($urandom_range(0, 9) < 8) ? 1'b0 : 1'b1;
      wen = ($urandom_range(0, 9) < 4) ? 1'b0 : 1'b1;
      oen = ($urandom_range(0, 9) < 6) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 3) == 0) addr = 8'($urandom_range(0, 7));
      dq_in   = 8'($urandom);
      ld_en   = ($urandom_range(0, 9) == 0);
      ld_addr = 8'($urandom_range(0, 7));
      ld_data = 8'($urandom);
      rst     = ($urandom_range(0, 59) == 0);
      step();
    end

    bus(1, 1, 1, 8'h00, 8'h00); step(); step();
    chk("queue_drain", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
